// File: rtl/fpmul_pkg.sv
// Shared definitions for the floating-point multiply scheduler.
//   state_t      : scheduler FSM states (also exported on the debug port)
//   ADDR_*       : register map of the multiplier wrapper bus
//   START_BIT    : bit of the control word that kicks off a multiply
//   FLAG_LSB/W   : position of {OF,UF,NANF,INFF,DNF,ZF} in the status word
package fpmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_A  = 3'd1,
        ST_WR_B  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RD_P  = 3'd5,
        ST_RD_S  = 3'd6,
        ST_RESP  = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_OPA  = 2'b00;
    localparam logic [1:0] ADDR_OPB  = 2'b01;
    localparam logic [1:0] ADDR_CTRL = 2'b10;
    // Result is read back through the same address the control word is written to.
    localparam logic [1:0] ADDR_RES  = 2'b10;
    localparam logic [1:0] ADDR_STAT = 2'b11;

    localparam int          START_BIT  = 16;
    localparam logic [31:0] CTRL_START = 32'h1 << START_BIT;

    localparam int FLAG_LSB = 8;
    localparam int FLAG_W   = 6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (combinational).
//   i_req[1:0] : request lines of requester 1 and 0
//   i_last     : ID of the requester served most recently
//   o_grant    : ID of the requester to serve next (meaningless when i_req == 0)
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant
);

    always_comb begin
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            // Tie: hand the grant to whoever was not served last.
            o_grant = ~i_last;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/fpmul_scheduler.sv
// Serialises multiply requests from two requesters onto one FP multiplier
// wrapper bus: writes both operands, starts the unit, waits for done (with
// timeout), reads result and status, then pulses the winner's Ack.
//
// Handshake: Req0/Req1 are levels held high until the matching one-cycle Ack;
// operands must stay stable while Req is high. A Req still high in the cycle
// after its Ack is a fresh request and competes in round-robin arbitration.
//
// Ports:
//   Clk, Rst              : clock, asynchronous active-high reset
//   Req0/1, OpA0/1, OpB0/1: requester inputs
//   Ack0/1, Result, Flags, Err : completion outputs, valid in the Ack cycle
//   Busy                  : high whenever the FSM is not idle
//   FpA, FpWE, FpWData    : wrapper bus master outputs
//   FpRData, FpDone       : wrapper read data (combinational) and done pulse
//   DbgState              : current FSM state for observation
module fpmul_scheduler
    import fpmul_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [31:0] OpA0,
    input  logic [31:0] OpB0,
    input  logic [31:0] OpA1,
    input  logic [31:0] OpB1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [31:0] Result,
    output logic [5:0]  Flags,
    output logic        Err,
    output logic        Busy,
    output logic [1:0]  FpA,
    output logic        FpWE,
    output logic [31:0] FpWData,
    input  logic [31:0] FpRData,
    input  logic        FpDone,
    output logic [2:0]  DbgState
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                r_state;
    logic                  r_winner;
    logic                  r_last;
    logic [CW-1:0]         r_cnt;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [31:0]           r_result;
    logic [FLAG_W-1:0]     r_flags;
    logic                  r_err;
    logic [1:0]            r_fp_a;
    logic                  r_fp_we;
    logic [31:0]           r_fp_wdata;

    logic                  w_grant;
    logic [31:0]           w_grant_op_a;
    logic [31:0]           w_winner_op_b;

    rr_arb2 u_arb (
        .i_req   ({Req1, Req0}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // Operand A is written in the cycle right after arbitration, so it is
    // selected by the fresh grant; operand B one cycle later by the latched winner.
    assign w_grant_op_a  = w_grant  ? OpA1 : OpA0;
    assign w_winner_op_b = r_winner ? OpB1 : OpB0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_winner   <= 1'b0;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
            r_err      <= 1'b0;
            r_fp_a     <= '0;
            r_fp_we    <= 1'b0;
            r_fp_wdata <= '0;
        end else begin
            // Bus and Ack outputs are pulses: idle unless a state below drives them.
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_fp_a     <= '0;
            r_fp_we    <= 1'b0;
            r_fp_wdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (Req0 || Req1) begin
                        r_winner   <= w_grant;
                        r_state    <= ST_WR_A;
                        r_fp_a     <= ADDR_OPA;
                        r_fp_we    <= 1'b1;
                        r_fp_wdata <= w_grant_op_a;
                    end
                end
                ST_WR_A: begin
                    r_state    <= ST_WR_B;
                    r_fp_a     <= ADDR_OPB;
                    r_fp_we    <= 1'b1;
                    r_fp_wdata <= w_winner_op_b;
                end
                ST_WR_B: begin
                    r_state    <= ST_START;
                    r_fp_a     <= ADDR_CTRL;
                    r_fp_we    <= 1'b1;
                    r_fp_wdata <= CTRL_START;
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Done wins over a timeout landing in the same cycle.
                    if (FpDone) begin
                        r_state <= ST_RD_P;
                        r_fp_a  <= ADDR_RES;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state  <= ST_RESP;
                        r_err    <= 1'b1;
                        r_result <= '0;
                        r_flags  <= '0;
                        r_ack0   <= ~r_winner;
                        r_ack1   <= r_winner;
                    end
                end
                ST_RD_P: begin
                    r_result <= FpRData;
                    r_state  <= ST_RD_S;
                    r_fp_a   <= ADDR_STAT;
                end
                ST_RD_S: begin
                    r_flags <= FpRData[FLAG_LSB +: FLAG_W];
                    r_err   <= 1'b0;
                    r_state <= ST_RESP;
                    r_ack0  <= ~r_winner;
                    r_ack1  <= r_winner;
                end
                ST_RESP: begin
                    r_last  <= r_winner;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Ack0     = r_ack0;
    assign Ack1     = r_ack1;
    assign Result   = r_result;
    assign Flags    = r_flags;
    assign Err      = r_err;
    assign Busy     = (r_state != ST_IDLE);
    assign FpA      = r_fp_a;
    assign FpWE     = r_fp_we;
    assign FpWData  = r_fp_wdata;
    assign DbgState = r_state;

endmodule

// File: tb/tb_fpmul_scheduler.sv
// Bench for fpmul_scheduler: a wrapper stub with a behavioural FP multiply,
// two requester drivers, and a transaction-level model of the scheduler
// (one job at a time, first free cycle, round-robin on ties, fixed latency).
module tb_fpmul_scheduler;

    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic        Req0 = 1'b0, Req1 = 1'b0;
    logic [31:0] OpA0 = '0, OpB0 = '0, OpA1 = '0, OpB1 = '0;
    logic        Ack0, Ack1, Err, Busy, FpWE, FpDone;
    logic [31:0] Result, FpWData, FpRData;
    logic [5:0]  Flags;
    logic [1:0]  FpA;
    logic [2:0]  DbgState;

    fpmul_scheduler #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
        .OpA0(OpA0), .OpB0(OpB0), .OpA1(OpA1), .OpB1(OpB1),
        .Ack0(Ack0), .Ack1(Ack1), .Result(Result), .Flags(Flags), .Err(Err),
        .Busy(Busy), .FpA(FpA), .FpWE(FpWE), .FpWData(FpWData),
        .FpRData(FpRData), .FpDone(FpDone), .DbgState(DbgState)
    );

    // ---------------- behavioural FP multiply: {flags, result} ----------------
    function automatic logic [37:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb, m;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31]; ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
        if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0) ||
            (ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0))
            return {6'b001000, 32'h7FC0_0000};
        if (ea == 8'hFF || eb == 8'hFF) return {6'b000100, s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0)
            return {4'b0000, ((ea == 0 && ma != 0) || (eb == 0 && mb != 0)), 1'b1, s, 31'h0};
        p = 48'({1'b1, ma}) * 48'({1'b1, mb});
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin m = p[46:24]; e++; end
        else m = p[45:23];
        if (e >= 255) return {6'b100100, s, 8'hFF, 23'h0};
        if (e <= 0) return {6'b010001, s, 31'h0};
        return {6'b000000, s, e[7:0], m};
    endfunction

    // ---------------- wrapper stub ----------------
    logic [31:0] w_a = '0, w_b = '0, w_res = '0;
    logic [5:0]  w_flags = '0;
    int          w_cnt = 0;
    int          d_q[$];   // done delay per started job (0 = never)

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            w_cnt <= 0;
        end else if (FpWE) begin
            if (FpA == 2'b00) w_a <= FpWData;
            if (FpA == 2'b01) w_b <= FpWData;
            if (FpA == 2'b10 && FpWData[16]) begin
                {w_flags, w_res} <= fmul(w_a, w_b);
                w_cnt <= (d_q.size() > 0) ? d_q.pop_front() : 0;
            end
        end else if (w_cnt > 0) begin
            w_cnt <= w_cnt - 1;
        end
    end

    assign FpDone  = (w_cnt == 1);
    assign FpRData = (FpA == 2'b10) ? w_res :
                     (FpA == 2'b11) ? {18'h0, w_flags, 8'h0} : 32'h0;

    // ---------------- bench state ----------------
    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic [1:0]  rq = '0;
    logic [31:0] opa[2], opb[2], dir_a[2], dir_b[2];
    int          rem[2], gap[2], gap_max[2], rs[2];
    bit          hold[2], ack_seen[2];
    bit          rnd_op = 0;
    int          d_mode = 3;   // >=0 fixed delay, -1 random
    // transaction model
    bit          m_busy = 0, m_to = 0;
    int          m_id = 0, m_last = 1, m_grant = 0, m_ack = 0, m_free = 0;
    logic [31:0] m_wa = '0, m_wb = '0;
    logic [38:0] exp_q[$];     // {err, flags, result}
    int          ack_log[$];
    logic [31:0] last_res;
    logic [5:0]  last_flg;
    logic        last_err;
    int          last_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        Req0 = rq[0]; Req1 = rq[1];
        OpA0 = opa[0]; OpB0 = opb[0]; OpA1 = opa[1]; OpB1 = opb[1];
    endtask

    task automatic new_ops(input int i);
        opa[i] = rnd_op ? $urandom : dir_a[i];
        opb[i] = rnd_op ? $urandom : dir_b[i];
        rs[i]  = cyc;
    endtask

    task automatic step();
        int         k, d;
        logic [38:0] e;
        @(posedge Clk); #1; cyc++;
        for (int i = 0; i < 2; i++) begin
            if (ack_seen[i]) begin
                ack_seen[i] = 0; rem[i]--;
                if (rem[i] > 0 && hold[i]) new_ops(i);
                else begin rq[i] = 1'b0; gap[i] = $urandom_range(0, gap_max[i]); end
            end else if (!rq[i] && rem[i] > 0) begin
                if (gap[i] == 0) begin rq[i] = 1'b1; new_ops(i); end
                else gap[i]--;
            end
        end
        drive();
        if (!m_busy && cyc >= m_free && rq != 2'b00) begin
            m_id = (rq == 2'b11) ? 1 - m_last : (rq[1] ? 1 : 0);
            if (d_mode >= 0) d = d_mode;
            else d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            d_q.push_back(d);
            m_to    = (d == 0 || d > TO);
            m_grant = cyc;
            m_ack   = cyc + (m_to ? 4 + TO : 6 + d);
            m_wa    = opa[m_id]; m_wb = opb[m_id];
            exp_q.push_back(m_to ? {1'b1, 38'h0} : {1'b0, fmul(m_wa, m_wb)});
            m_busy  = 1;
        end
        @(negedge Clk);
        k = cyc - m_grant;
        chk("busy", Busy, m_busy && k >= 1);
        chk("fp_we", FpWE, m_busy && k >= 1 && k <= 3);
        chk("fp_wdata", FpWData, !m_busy ? 32'h0 : (k == 1) ? m_wa : (k == 2) ? m_wb :
                                 (k == 3) ? 32'h0001_0000 : 32'h0);
        if (m_busy && k >= 1 && k <= 3) chk("fp_a_wr", FpA, k - 1);
        if (m_busy && !m_to && cyc == m_ack - 2) chk("fp_a_rd_p", FpA, 2);
        if (m_busy && !m_to && cyc == m_ack - 1) chk("fp_a_rd_s", FpA, 3);
        chk("ack0", Ack0, m_busy && cyc == m_ack && m_id == 0);
        chk("ack1", Ack1, m_busy && cyc == m_ack && m_id == 1);
        if (m_busy && cyc == m_ack) begin
            e = exp_q.pop_front();
            chk("result", Result, e[31:0]);
            chk("flags", Flags, e[37:32]);
            chk("err", Err, e[38]);
            last_res = Result; last_flg = Flags; last_err = Err;
            last_lat = cyc - rs[m_id];
            ack_log.push_back(m_id);
            m_busy = 0; m_last = m_id; m_free = cyc + 1; ack_seen[m_id] = 1;
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((rem[0] > 0 || rem[1] > 0 || m_busy) && n < budget) begin step(); n++; end
        chk("drain_budget", (rem[0] > 0 || rem[1] > 0 || m_busy), 0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge Clk); #1;
        Rst = 1'b1; rq = '0;
        rem = '{0, 0}; gap = '{0, 0}; ack_seen = '{0, 0};
        drive(); #1;
        chk("rst_busy", Busy, 0);   chk("rst_we", FpWE, 0);
        chk("rst_wdata", FpWData, 0); chk("rst_fpa", FpA, 0);
        chk("rst_ack0", Ack0, 0);   chk("rst_ack1", Ack1, 0);
        chk("rst_err", Err, 0);     chk("rst_result", Result, 0);
        chk("rst_flags", Flags, 0);
        repeat (cycles) @(posedge Clk);
        m_busy = 0; m_last = 1; exp_q.delete(); d_q.delete();
        #1 Rst = 1'b0;
        m_free = cyc + 1;
    endtask

    task automatic setup(input int r0, input int r1, input bit h0, input bit h1,
                         input int g0, input int g1);
        rem = '{r0, r1}; hold = '{h0, h1}; gap = '{g0, g1}; gap_max = '{g0, g1};
        ack_log.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        opa = '{0, 0}; opb = '{0, 0}; rs = '{0, 0};
        do_reset(2);

        // Simultaneous requests after reset: requester 0 first, then 1.
        dir_a = '{32'h4000_0000, 32'h3FC0_0000};
        dir_b = '{32'h4040_0000, 32'hC000_0000};
        d_mode = 2;
        setup(1, 1, 0, 0, 0, 0);
        run(100);
        chk("tie_count", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            chk("tie_first", ack_log[0], 0);
            chk("tie_second", ack_log[1], 1);
        end

        // 2.0 * 3.0 = 6.0 on requester 0 alone.
        d_mode = 3;
        setup(1, 0, 0, 0, 0, 0);
        run(100);
        chk("mul_result", last_res, 32'h40C0_0000);
        chk("mul_flags", last_flg, 6'h00);
        chk("mul_err", last_err, 0);
        chk("mul_latency", last_lat, 9);

        // inf * 2.0 = inf with INFF.
        dir_a[0] = 32'h7F80_0000; dir_b[0] = 32'h4000_0000;
        setup(1, 0, 0, 0, 0, 0);
        run(100);
        chk("inf_result", last_res, 32'h7F80_0000);
        chk("inf_flags", last_flg, 6'b000100);

        // Requester 1 holds, requester 0 pulses: grants alternate.
        d_mode = 1;
        setup(2, 3, 0, 1, 2, 0);
        gap_max[0] = 0;
        run(200);
        chk("rr_count", ack_log.size(), 5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++) chk("rr_order", ack_log[i], (i % 2 == 0) ? 1 : 0);

        // Timeout: done never arrives.
        dir_a[0] = 32'h4000_0000; dir_b[0] = 32'h4040_0000;
        d_mode = 0;
        setup(1, 0, 0, 0, 0, 0);
        run(100);
        chk("to_err", last_err, 1);
        chk("to_result", last_res, 0);
        chk("to_flags", last_flg, 0);
        chk("to_latency", last_lat, 4 + TO);

        // Done in the very cycle the timeout would fire: normal completion.
        d_mode = TO;
        setup(1, 0, 0, 0, 0, 0);
        run(100);
        chk("edge_err", last_err, 0);
        chk("edge_result", last_res, 32'h40C0_0000);
        chk("edge_latency", last_lat, 6 + TO);

        // Reset during WAIT: abandoned, then a fresh request completes.
        d_mode = 0;
        setup(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 30 && !(m_busy && cyc >= m_grant + 6); n++) step();
        chk("pre_rst_busy", Busy, 1);
        ack_log.delete();
        do_reset(2);
        chk("rst_no_ack", ack_log.size(), 0);
        d_mode = 3;
        setup(1, 0, 0, 0, 0, 0);
        run(100);
        chk("post_rst_err", last_err, 0);
        chk("post_rst_result", last_res, 32'h40C0_0000);

        // Random traffic: random operands, delays and occasional timeouts.
        rnd_op = 1; d_mode = -1;
        setup(15, 15, 1, 0, 3, 3);
        run(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpmul_scheduler.md
FPMUL_SCHEDULER -- requirements
Module: fpmul_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles from start write to FpDone before abort.
REQ-002 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports Req0/Req1  input  1  requester 0/1 multiply request, level, held until its Ack.
REQ-005 SHALL have ports OpA0/OpB0/OpA1/OpB1  input  32  operands, stable while the matching Req is high.
REQ-006 SHALL have ports Ack0/Ack1  output  1  one-cycle completion pulse per requester.
REQ-007 SHALL have port Result  output  32  product, valid in the Ack cycle.
REQ-008 SHALL have port Flags  output  6  {OF,UF,NANF,INFF,DNF,ZF}, valid in the Ack cycle.
REQ-009 SHALL have port Err  output  1  timeout indication, valid in the Ack cycle.
REQ-010 SHALL have port Busy  output  1  high in every non-IDLE state.
REQ-011 SHALL have ports FpA  output  2, FpWE  output  1, FpWData  output  32  multiplier-wrapper bus master side.
REQ-012 SHALL have ports FpRData  input  32, FpDone  input  1  wrapper read data (combinational) and done pulse.

Function
REQ-013 SHALL implement states IDLE, WR_A, WR_B, START, WAIT, RD_P, RD_S, RESP; one state per cycle except WAIT.
REQ-014 IDLE: if any Req high, latch winner ID, go WR_A next cycle; else stay.
REQ-015 Arbitration SHALL be round-robin: both requesting -> grant the one not served last; reset value of last-served = 1 (requester 0 wins first tie).
REQ-016 WR_A: FpA=ADDR_OPA, FpWE=1, FpWData=winner OpA; WR_B: FpA=ADDR_OPB, FpWE=1, FpWData=winner OpB.
REQ-017 START: FpA=ADDR_CTRL, FpWE=1, FpWData=32'h0001_0000 (bit 16 set); timeout counter cleared.
REQ-018 WAIT: FpWE=0; counter increments each cycle; FpDone=1 -> RD_P; counter reaching TIMEOUT without FpDone -> RESP with Err=1.
REQ-019 FpDone arriving in the same cycle the counter hits TIMEOUT SHALL take priority (normal completion, Err=0).
REQ-020 RD_P: FpA=ADDR_RES, capture FpRData into result register; RD_S: FpA=ADDR_STAT, capture FpRData[13:8] into flags register.
REQ-021 RESP: assert Ack of winner only, drive Result/Flags/Err from registers, record winner as last-served, return to IDLE.
REQ-022 On timeout Result SHALL be 0 and Flags 0.
REQ-023 A Req still high in the cycle after its Ack SHALL be treated as a new request, subject to REQ-015.
REQ-024 Outside REQ-016/017 FpWE SHALL be 0; FpWData SHALL be 0 when FpWE=0.
REQ-025 Request-to-Ack latency SHALL be 6 + N cycles, N = WAIT cycles up to and including the FpDone cycle.

Reset
REQ-026 Rst high SHALL immediately force IDLE, Ack0=Ack1=0, Busy=0, Err=0, FpWE=0, FpA=0, FpWData=0, Result=0, Flags=0, counter=0, last-served=1.
REQ-027 Rst mid-operation SHALL abandon the transaction with no Ack; requester must re-request.

Structure
REQ-028 State encoding, ADDR_OPA=2'b00, ADDR_OPB=2'b01, ADDR_CTRL=2'b10, ADDR_RES=2'b10, ADDR_STAT=2'b11 and START_BIT=16 SHALL live in shared package fpmul_pkg.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output grant ID).

Verification
REQ-030 Req0 only, OpA0=32'h4000_0000, OpB0=32'h4040_0000, wrapper attached -> Ack0 pulse, Result=32'h40C0_0000, Flags=0, Err=0.
REQ-031 Req0 and Req1 rise same cycle -> requester 0 served first, then requester 1; Ack0 precedes Ack1; no cycle with both Acks.
REQ-032 Req1 held continuously, Req0 pulses request -> grants alternate 1,0,1 with no starvation.
REQ-033 Stub wrapper never asserts FpDone, TIMEOUT=8 -> Ack after 8 WAIT cycles with Err=1, Result=0.
REQ-034 Rst pulsed during WAIT -> Busy=0, FpWE=0 same cycle, no Ack; subsequent request completes normally.
REQ-035 OpA0=32'h7F80_0000 (inf) x OpB0=32'h4000_0000 -> Result=32'h7F80_0000, Flags INFF=1.
